ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit for the single-issue MIPS core: the initiator side of the instruction-memory interface. It owns the fetch PC, drives the word-aligned byte address to the instruction ROM, captures the returned word in the same cycle, and buffers fetched words in a small queue. The queue feeds decode through a valid/ready handshake. Branch/jump redirects from the execute stage flush the queue and restart fetch; illegal targets raise a sticky fault.

## Interface
- RESET_PC, 32'h00003000, first fetch address after reset; base of the instruction ROM window.
- IM_WORDS, 2048, ROM depth in words; legal fetch range is [RESET_PC, RESET_PC + 4*IM_WORDS).
- DEPTH, 2, queue entries; power of two, ≥2.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- im_addr  out  32  byte address to instruction ROM; equals fetch_pc register.
- im_instr  in  32  ROM word at im_addr, valid combinationally in the same cycle.
- redirect_valid  in  1  one-cycle pulse: discard queued/in-flight fetches and restart at redirect_pc.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  32  head instruction word.
- out_pc  out  32  byte address of head instruction.
- fault  out  1  sticky: fetch stopped on misaligned or out-of-range PC.

## Operation
- State: fetch_pc (32b), circular queue of DEPTH {pc, instr} entries, rd_ptr/wr_ptr, count (0..DEPTH), fault flag.
- pop = out_valid & out_ready.
- push = !fault & !redirect_valid & pc_legal(fetch_pc) & (count < DEPTH | pop).
- pc_legal(p) = (p[1:0] == 0) & (p ≥ RESET_PC) & (p − RESET_PC < 4*IM_WORDS); compare in 32b unsigned arithmetic, no wrap past 2^32.
- On push: write {fetch_pc, im_instr} at wr_ptr; fetch_pc ← fetch_pc + 4.
- Pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged. Pop when count==0 is impossible because out_valid=0.
- A full queue with pop still pushes (full throughput). A full queue without pop holds fetch_pc and im_addr.
- Sequential fault: if !fault & !redirect_valid & !pc_legal(fetch_pc), then fault ← 1 and no push. Entries already queued still drain normally.
- Redirect (priority over everything except reset):
  - count ← 0 and pointers ← 0.
  - A pop in the same cycle still completes; decode consumed that entry.
  - fetch_pc ← redirect_pc, with no push that cycle.
  - fault ← !pc_legal(redirect_pc).
  - An illegal target sets fault immediately; the next legal redirect clears it.
- fault clears only on reset or a legal redirect.

## Timing
- Reset values: fetch_pc = im_addr = RESET_PC; count = 0; out_valid = 0; out_instr = 0; out_pc = 0; fault = 0; queue contents 0.
- im_addr comes directly from a register, so there is no combinational path from inputs to im_addr.
- out_valid/out_instr/out_pc come from registers (count != 0, head entry), so there are no combinational paths from out_ready or redirect.
- Fetch-to-out latency: a word pushed in cycle N is visible at out_* in cycle N+1 if it is at the head.
- First out_valid is the first rising edge after rst_n deasserts, plus 1 cycle.
- Redirect asserted in cycle N: out_valid=0 in cycle N+1; the target instruction appears in cycle N+2.
- Head is stable while out_valid & !out_ready.
- With out_ready held at 1 and legal sequential PCs, throughput is 1 instruction/cycle.
- rst_n asserted mid-operation: all state returns to reset values immediately (asynchronously). Pending entries are lost.

## Test plan
- Reset release, out_ready=1, ROM words W0..W3 at 0x3000..0x300C: out_pc = 0x3000, 0x3004, 0x3008, 0x300C on consecutive cycles with out_instr = W0..W3. out_valid rises 1 cycle after first fetch.
- Backpressure: out_ready=0 for 5 cycles after first valid. count saturates at 2, out_pc holds 0x3000, im_addr holds at 0x3008. Releasing ready yields 0x3000, 0x3004, 0x3008 with no gap, loss, or duplicate.
- Redirect with queue full and out_ready=0, redirect_pc=0x3100: next cycle out_valid=0. The following cycle out_pc=0x3100 with ROM[0x40]. The old entries never appear.
- Redirect 0x3102 (misaligned), then 0x2FFC (below base): fault=1 the next cycle, out_valid=0, im_addr frozen. A subsequent redirect to 0x3000 clears fault and resumes at 0x3000.
- Run-off-end: redirect 0x4FFC. One instruction with out_pc=0x4FFC is delivered, then fault=1 with fetch_pc=0x5000 and no further pushes.
- rst_n pulsed low mid-stream with 2 queued entries: out_valid, fault, and count go to 0 and im_addr goes to 0x3000 without waiting for a clock edge. Fetch restarts from 0x3000 after release.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, reads the instruction ROM combinationally and
// buffers {pc, instr} pairs in a small circular queue feeding decode via valid/ready.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 2048,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthC     = CntW'(DEPTH);
  localparam logic [31:0]     RangeBytes = 32'(IM_WORDS) << 2;

  // Offset is only compared after p >= RESET_PC holds, so the subtraction cannot wrap.
  function automatic logic pc_legal(input logic [31:0] p);
    logic [31:0] off;
    off = p - RESET_PC;
    return (p[1:0] == 2'b00) && (p >= RESET_PC) && (off < RangeBytes);
  endfunction

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            fault_q, fault_d;
  logic [31:0]     q_pc_q    [DEPTH];
  logic [31:0]     q_instr_q [DEPTH];

  logic pc_ok;
  logic full;
  logic pop;
  logic push;

  assign pc_ok = pc_legal(fetch_pc_q);
  assign full  = (count_q == DepthC);
  assign pop   = (count_q != '0) & out_ready;
  assign push  = ~fault_q & ~redirect_valid & pc_ok & (~full | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fault_d    = fault_q;
    if (redirect_valid) begin
      // A same-cycle pop needs no bookkeeping: the whole queue is discarded anyway.
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fault_d    = ~pc_legal(redirect_pc);
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (!fault_q && !pc_ok) begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fault_q    <= fault_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_pc_q[i]    <= '0;
        q_instr_q[i] <= '0;
      end
    end else if (push) begin
      q_pc_q[wr_ptr_q]    <= fetch_pc_q;
      q_instr_q[wr_ptr_q] <= im_instr;
    end
  end

  assign im_addr   = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = q_pc_q[rd_ptr_q];
  assign out_instr = q_instr_q[rd_ptr_q];
  assign fault     = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: behavioural ROM, directed scenarios, and a scoreboard of expected
// {pc, instr} transfers checked by a monitor on every accepted handshake.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  ifu_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_addr        (im_addr),
    .im_instr       (im_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  assign im_instr = rom_word(im_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    sb.push_back({pc, rom_word(pc)});
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step(1);
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic sb_drained(input string name);
    chk(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Monitor: every accepted transfer must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_xfer: got pc %h instr %h expected none", out_pc, out_instr);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({out_pc, out_instr} !== e) begin
          errors++;
          $display("FAIL xfer: got pc %h instr %h expected pc %h instr %h",
                   out_pc, out_instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step(2);
    chk("rst_im_addr", im_addr, 32'h3000);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);

    // Streaming from reset.
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) expect_pc(32'h3000 + 32'(4 * i));
    chk("first_valid_low", 32'(out_valid), 32'd0);
    step(1);
    chk("first_valid_high", 32'(out_valid), 32'd1);
    chk("first_pc", out_pc, 32'h3000);
    step(4);
    out_ready = 1'b0;
    sb_drained("stream_drain");

    // Backpressure.
    do_reset();
    step(1);
    chk("bp_valid", 32'(out_valid), 32'd1);
    step(4);
    chk("bp_hold_pc", out_pc, 32'h3000);
    chk("bp_hold_instr", out_instr, rom_word(32'h3000));
    chk("bp_im_addr", im_addr, 32'h3008);
    for (int i = 0; i < 3; i++) expect_pc(32'h3000 + 32'(4 * i));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_no_gap", 32'(out_valid), 32'd1);
      step(1);
    end
    out_ready = 1'b0;
    sb_drained("bp_drain");

    // Redirect with full queue and no ready.
    chk("rd_full_valid", 32'(out_valid), 32'd1);
    do_redirect(32'h3100);
    chk("rd_bubble", 32'(out_valid), 32'd0);
    chk("rd_im_addr", im_addr, 32'h3100);
    step(1);
    chk("rd_tgt_valid", 32'(out_valid), 32'd1);
    chk("rd_tgt_pc", out_pc, 32'h3100);
    chk("rd_tgt_instr", out_instr, rom_word(32'h3100));
    expect_pc(32'h3100);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    sb_drained("rd_drain");

    // Illegal redirect targets.
    do_redirect(32'h3102);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_valid", 32'(out_valid), 32'd0);
    step(2);
    chk("mis_frozen", im_addr, 32'h3102);
    chk("mis_valid2", 32'(out_valid), 32'd0);
    do_redirect(32'h2FFC);
    chk("low_fault", 32'(fault), 32'd1);
    step(2);
    chk("low_frozen", im_addr, 32'h2FFC);
    chk("low_valid", 32'(out_valid), 32'd0);
    do_redirect(32'h3000);
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_im_addr", im_addr, 32'h3000);
    step(1);
    chk("clr_pc", out_pc, 32'h3000);
    expect_pc(32'h3000);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    sb_drained("clr_drain");

    // Run off the end of the ROM window.
    do_redirect(32'h4FFC);
    expect_pc(32'h4FFC);
    out_ready = 1'b1;
    step(1);
    chk("end_valid", 32'(out_valid), 32'd1);
    chk("end_fault0", 32'(fault), 32'd0);
    step(1);
    chk("end_fault1", 32'(fault), 32'd1);
    chk("end_im_addr", im_addr, 32'h5000);
    chk("end_valid0", 32'(out_valid), 32'd0);
    step(3);
    chk("end_stopped", 32'(out_valid), 32'd0);
    chk("end_frozen", im_addr, 32'h5000);
    out_ready = 1'b0;
    sb_drained("end_drain");

    // Async reset with two queued entries and fault set.
    do_redirect(32'h4FF8);
    step(3);
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    chk("ar_pre_fault", 32'(fault), 32'd1);
    chk("ar_pre_pc", out_pc, 32'h4FF8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_fault", 32'(fault), 32'd0);
    chk("ar_im_addr", im_addr, 32'h3000);
    chk("ar_pc", out_pc, 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("ar_restart_valid", 32'(out_valid), 32'd1);
    chk("ar_restart_pc", out_pc, 32'h3000);
    chk("ar_restart_instr", out_instr, rom_word(32'h3000));
    sb_drained("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
